// File: rtl/cp0_irq.sv
// Coprocessor-0 interrupt/exception block: SR, Cause, EPC and PRId,
// with level-sensitive interrupt request, exception entry and eret.
module cp0_irq #(
    parameter logic [31:0] PRID = 32'h0000_4D49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [5:0]  hw_int,
    input  logic [29:0] pc,
    input  logic        exl_set,
    input  logic [4:0]  exc_code,
    input  logic        exl_clr,
    output logic        int_req,
    output logic [31:0] epc
);

    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic [5:0]  ip;
    logic [4:0]  exccode;
    logic [29:0] epc_q;

    logic        wr_sr;
    logic        wr_epc;
    logic        take_exc;

    assign int_req  = (|(ip & im)) & ie & ~exl;
    assign epc      = {epc_q, 2'b00};

    assign wr_sr    = we && (addr == A_SR);
    assign wr_epc   = we && (addr == A_EPC);
    assign take_exc = exl_set && !exl;

    // exl_set blocks eret and mtc0 in its cycle even when it is itself
    // ignored because a handler is already running.
    always_ff @(posedge clk) begin
        if (reset) begin
            im      <= '0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            ip      <= '0;
            exccode <= '0;
            epc_q   <= '0;
        end else begin
            ip <= hw_int;
            if (exl_set) begin
                if (take_exc) begin
                    exl     <= 1'b1;
                    epc_q   <= pc;
                    exccode <= int_req ? 5'd0 : exc_code;
                end
            end else begin
                if (wr_sr) begin
                    im  <= din[15:10];
                    ie  <= din[0];
                    exl <= din[1] & ~exl_clr;
                end else if (exl_clr) begin
                    exl <= 1'b0;
                end
                if (wr_epc) begin
                    epc_q <= din[31:2];
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            A_SR:    dout = {16'h0, im, 8'h0, exl, ie};
            A_CAUSE: dout = {16'h0, ip, 3'b000, exccode, 2'b00};
            A_EPC:   dout = {epc_q, 2'b00};
            A_PRID:  dout = PRID;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq.sv
// Bench for cp0_irq: directed vector table plus random stimulus
// checked against a word-level model of the CP0 registers.
module tb_cp0_irq;

    localparam logic [31:0] PRID = 32'h0000_4D49;

    logic        clk;
    logic        reset;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [5:0]  hw_int;
    logic [29:0] pc;
    logic        exl_set;
    logic [4:0]  exc_code;
    logic        exl_clr;
    logic        int_req;
    logic [31:0] epc;

    int n_chk;
    int n_fail;

    cp0_irq #(.PRID(PRID)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din),
        .dout(dout), .hw_int(hw_int), .pc(pc), .exl_set(exl_set),
        .exc_code(exc_code), .exl_clr(exl_clr), .int_req(int_req),
        .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [5:0]  hw;
        logic [29:0] pc;
        logic        es;
        logic [4:0]  ec;
        logic        clr;
        logic [4:0]  chk;
        logic [31:0] xd;
        logic        xi;
        logic [31:0] xe;
    } vec_t;

    localparam int NV = 25;
    vec_t vt[NV];

    function automatic vec_t mk(input int rst, input int w, input int a,
                                input int d, input int hw, input int p,
                                input int es, input int ec, input int clr,
                                input int chk, input int xd, input int xi,
                                input int xe);
        vec_t v;
        v.rst  = 1'(rst);
        v.we   = 1'(w);
        v.addr = 5'(a);
        v.din  = 32'(d);
        v.hw   = 6'(hw);
        v.pc   = 30'(p);
        v.es   = 1'(es);
        v.ec   = 5'(ec);
        v.clr  = 1'(clr);
        v.chk  = 5'(chk);
        v.xd   = 32'(xd);
        v.xi   = 1'(xi);
        v.xe   = 32'(xe);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model state, kept as architectural register words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    function automatic logic m_req();
        return (|(m_cause[15:10] & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        logic [31:0] sr, cause, e;
        logic        req;
        sr    = m_sr;
        cause = m_cause;
        e     = m_epc;
        req   = m_req();
        if (reset) begin
            sr = 0; cause = 0; e = 0;
        end else begin
            if (exl_set) begin
                if (!m_sr[1]) begin
                    sr    = sr | 32'h2;
                    e     = {pc, 2'b00};
                    cause = (cause & ~32'h7C) |
                            (req ? 32'h0 : {25'h0, exc_code, 2'b00});
                end
            end else begin
                if (we && addr == 5'd12) sr = din & 32'h0000_FC03;
                if (exl_clr) sr = sr & ~32'h2;
                if (we && addr == 5'd14) e = din & ~32'h3;
            end
            cause = (cause & ~32'hFC00) | {16'h0, hw_int, 10'h0};
        end
        m_sr    = sr;
        m_cause = cause;
        m_epc   = e;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1; we = 1'b0; addr = '0; din = '0; hw_int = '0;
        pc = '0; exl_set = 1'b0; exc_code = '0; exl_clr = 1'b0;

        //          rst we a  din   hw  pc    es ec clr chk xd     xi xe
        vt[0]  = mk(1, 0, 0, 0,     0,  0,    0, 0, 0, 12, 0,      0, 0);
        vt[1]  = mk(0, 0, 0, 0,     0,  0,    0, 0, 0, 13, 0,      0, 0);
        vt[2]  = mk(0, 0, 0, 0,     0,  0,    0, 0, 0, 14, 0,      0, 0);
        vt[3]  = mk(0, 0, 0, 0,     0,  0,    0, 0, 0, 15, 'h4D49, 0, 0);
        vt[4]  = mk(0, 0, 0, 0,   'h3F, 0,    0, 0, 0, 12, 0,      0, 0);
        vt[5]  = mk(0, 1, 12,'h401, 0,  0,    0, 0, 0, 12, 'h401,  0, 0);
        vt[6]  = mk(0, 0, 0, 0,     1,  0,    0, 0, 0, 13, 'h400,  1, 0);
        vt[7]  = mk(0, 0, 0, 0,     2,  0,    0, 0, 0, 13, 'h800,  0, 0);
        vt[8]  = mk(0, 0, 0, 0,     1,  0,    0, 0, 0, 12, 'h401,  1, 0);
        vt[9]  = mk(0, 0, 0, 0,     1, 'hC05, 1, 10,0, 12, 'h403,  0, 'h3014);
        vt[10] = mk(0, 0, 0, 0,     0,  0,    0, 0, 1, 13, 0,      0, 'h3014);
        vt[11] = mk(0, 0, 0, 0,     0, 'h10,  1, 12,0, 13, 'h30,   0, 'h40);
        vt[12] = mk(0, 0, 0, 0,     0, 'h20,  1, 5, 0, 14, 'h40,   0, 'h40);
        vt[13] = mk(0, 0, 0, 0,     0,  0,    0, 0, 0, 13, 'h30,   0, 'h40);
        vt[14] = mk(0, 1, 12,'hFC03,1,  0,    0, 0, 1, 12, 'hFC01, 1, 'h40);
        vt[15] = mk(0, 0, 0, 0,     1,  0,    0, 0, 0, 12, 'hFC01, 1, 'h40);
        vt[16] = mk(0, 1, 14,'h3007,0,  0,    0, 0, 0, 14, 'h3004, 0, 'h3004);
        vt[17] = mk(0, 1, 14,'h3007,0, 'h100, 1, 0, 0, 14, 'h400,  0, 'h400);
        vt[18] = mk(0, 0, 0, 0,     1,  0,    0, 0, 0, 12, 'hFC03, 0, 'h400);
        vt[19] = mk(1, 0, 0, 0,     1,  0,    0, 0, 0, 12, 0,      0, 0);
        vt[20] = mk(0, 0, 0, 0,     1,  0,    0, 0, 0, 13, 'h400,  0, 0);
        vt[21] = mk(0, 1, 13,-1,    1,  0,    0, 0, 0, 13, 'h400,  0, 0);
        vt[22] = mk(0, 1, 15, 0,    0,  0,    0, 0, 0, 15, 'h4D49, 0, 0);
        vt[23] = mk(0, 0, 0, 0,     0,  5,    1, 3, 1, 12, 'h2,    0, 'h14);
        vt[24] = mk(0, 0, 0, 0,     0,  0,    0, 0, 0, 13, 'hC,    0, 'h14);

        for (int i = 0; i < NV; i++) begin
            reset = vt[i].rst; we = vt[i].we; addr = vt[i].addr;
            din = vt[i].din; hw_int = vt[i].hw; pc = vt[i].pc;
            exl_set = vt[i].es; exc_code = vt[i].ec; exl_clr = vt[i].clr;
            @(posedge clk);
            #1;
            reset = 1'b0; we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0;
            addr = vt[i].chk;
            #1;
            check($sformatf("vec%0d dout", i), dout, vt[i].xd);
            check($sformatf("vec%0d int_req", i), {31'h0, int_req},
                  {31'h0, vt[i].xi});
            check($sformatf("vec%0d epc", i), epc, vt[i].xe);
        end

        m_sr = 0; m_cause = 0; m_epc = 0;
        for (int i = 0; i < 3000; i++) begin
            reset    = (i == 0) || ($urandom_range(0, 99) == 0);
            we       = ($urandom_range(0, 3) == 0);
            addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                                   : 5'($urandom_range(12, 15));
            din      = $urandom;
            hw_int   = ($urandom_range(0, 1) == 0) ? 6'h0 : 6'($urandom);
            pc       = 30'($urandom);
            exl_set  = ($urandom_range(0, 7) == 0);
            exc_code = 5'($urandom);
            exl_clr  = ($urandom_range(0, 5) == 0);
            #2;
            if (i > 0) begin
                check("rand dout", dout, m_read(addr));
                check("rand int_req", {31'h0, int_req}, {31'h0, m_req()});
                check("rand epc", epc, m_epc);
            end
            m_step();
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
